hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Detects load-use hazards, resolves

---
 rtl/hazard_stall_ctrl_if.sv | 39 +++
 rtl/hazard_stall_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the 5-stage datapath and hazard_stall_ctrl.
// master: datapath side (drives hazard inputs, receives controls).
// slave : sequencer side.
interface hazard_stall_ctrl_if #(
    parameter int RA_W = 5
);
    logic            start_i;
    logic            halt_i;
    logic [RA_W-1:0] id_rs1_i;
    logic [RA_W-1:0] id_rs2_i;
    logic            id_rs1_use_i;
    logic            id_rs2_use_i;
    logic            id_br_taken_i;
    logic            idex_memread_i;
    logic [RA_W-1:0] idex_rd_i;
    logic            exmem_memreq_i;
    logic            dmem_ack_i;
    logic            pc_we_o;
    logic            ifid_we_o;
    logic            ifid_flush_o;
    logic            idex_bubble_o;
    logic            pipe_hold_o;
    logic            memwb_bubble_o;
    logic            halted_o;

    modport master (
        output start_i, halt_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
               id_br_taken_i, idex_memread_i, idex_rd_i, exmem_memreq_i, dmem_ack_i,
        input  pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               memwb_bubble_o, halted_o
    );

    modport slave (
        input  start_i, halt_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
               id_br_taken_i, idex_memread_i, idex_rd_i, exmem_memreq_i, dmem_ack_i,
        output pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               memwb_bubble_o, halted_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and data-memory
// freezes for the 5-stage core. Outputs are combinational from state + inputs.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hazard_stall_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_MEM_WAIT,
        ST_HALT
    } state_t;

    state_t state_q, state_d;
    logic   lu;

    // Load-use hazard: EX holds a load whose rd is read by the ID instruction.
    always_comb begin
        lu = hz.idex_memread_i && (hz.idex_rd_i != RA_W'(0)) &&
             ((hz.id_rs1_use_i && (hz.idex_rd_i == hz.id_rs1_i)) ||
              (hz.id_rs2_use_i && (hz.idex_rd_i == hz.id_rs2_i)));
    end

    // State register; reset wins over every state, including MEM_WAIT.
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        state_d           = state_q;
        hz.pc_we_o        = 1'b0;
        hz.ifid_we_o      = 1'b0;
        hz.ifid_flush_o   = 1'b0;
        hz.idex_bubble_o  = 1'b0;
        hz.pipe_hold_o    = 1'b0;
        hz.memwb_bubble_o = 1'b0;
        hz.halted_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hz.idex_bubble_o  = 1'b1;
                hz.memwb_bubble_o = 1'b1;
                if (hz.start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (hz.exmem_memreq_i && !hz.dmem_ack_i) begin
                    hz.pipe_hold_o    = 1'b1;
                    hz.memwb_bubble_o = 1'b1;
                    state_d           = ST_MEM_WAIT;
                end else if (hz.halt_i) begin
                    hz.idex_bubble_o = 1'b1;
                    state_d          = ST_HALT;
                end else if (lu) begin
                    hz.idex_bubble_o = 1'b1;
                end else if (hz.id_br_taken_i) begin
                    hz.pc_we_o      = 1'b1;
                    hz.ifid_we_o    = 1'b1;
                    hz.ifid_flush_o = 1'b1;
                end else begin
                    hz.pc_we_o   = 1'b1;
                    hz.ifid_we_o = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // Ack cycle releases the pipe; hazards are looked at again in RUN.
                if (hz.dmem_ack_i) begin
                    hz.pc_we_o   = 1'b1;
                    hz.ifid_we_o = 1'b1;
                    state_d      = ST_RUN;
                end else begin
                    hz.pipe_hold_o    = 1'b1;
                    hz.memwb_bubble_o = 1'b1;
                end
            end
            ST_HALT: begin
                hz.idex_bubble_o  = 1'b1;
                hz.memwb_bubble_o = 1'b1;
                hz.halted_o       = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    logic             active;
    logic [CNT_W-1:0] cyc_q, stall_q, flush_q;
    logic [CNT_W-1:0] cyc_d, stall_d, flush_d;

    // Counter next values; wrap naturally at 2^CNT_W, frozen outside RUN/MEM_WAIT.
    always_comb begin
        active  = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
        cyc_d   = cyc_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (active)                  cyc_d   = cyc_q + CNT_W'(1);
        if (active && !hz.pc_we_o)   stall_d = stall_q + CNT_W'(1);
        if (hz.ifid_flush_o)         flush_d = flush_q + CNT_W'(1);
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign cyc_cnt_o   = cyc_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios then random traffic,
// checked against a behavioural model of the sequencing rules.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.RA_W(5)) bus ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
`endif

    hazard_stall_ctrl #(.RA_W(5), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .hz    (bus)
`ifdef HAZ_PERF_CNT_EN
        ,
        .cyc_cnt_o   (cyc_cnt),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    typedef struct packed {
        logic [5:0]  ctrl;   // pc_we, ifid_we, flush, idex_bubble, hold, memwb_bubble
        logic        halted;
        logic [31:0] cyc;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Model: the core is either not started, running, waiting on memory or halted.
    bit          m_started, m_waiting, m_halted;
    bit          n_started, n_waiting, n_halted;
    logic [31:0] m_cyc, m_stall, m_flush, n_cyc, n_stall, n_flush;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s got=%0h expected=%0h @%0t", name, got, want, $time);
    endtask

    // Monitor: every cycle the DUT presents its controls; compare against queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ctrl", 32'({bus.pc_we_o, bus.ifid_we_o, bus.ifid_flush_o,
                                 bus.idex_bubble_o, bus.pipe_hold_o, bus.memwb_bubble_o}),
                    32'(e.ctrl));
                chk("halted", 32'(bus.halted_o), 32'(e.halted));
`ifdef HAZ_PERF_CNT_EN
                chk("cyc_cnt", cyc_cnt, e.cyc);
                chk("stall_cnt", stall_cnt, e.stall);
                chk("flush_cnt", flush_cnt, e.flush);
`endif
            end
        end
    end

    // Compute expected response for current inputs, queue it, advance one clock.
    task automatic step();
        exp_t e;
        bit   pc, fw, fl, ib, ho, mb, lu, active;
        pc = 0; fw = 0; fl = 0; ib = 0; ho = 0; mb = 0;
        n_started = m_started; n_waiting = m_waiting; n_halted = m_halted;
        lu = bus.idex_memread_i && bus.idex_rd_i != 0 &&
             ((bus.id_rs1_use_i && bus.idex_rd_i == bus.id_rs1_i) ||
              (bus.id_rs2_use_i && bus.idex_rd_i == bus.id_rs2_i));
        if (m_halted || !m_started) begin
            ib = 1; mb = 1;
            if (!m_halted && bus.start_i) n_started = 1;
        end else if (m_waiting) begin
            if (bus.dmem_ack_i) begin pc = 1; fw = 1; n_waiting = 0; end
            else begin ho = 1; mb = 1; end
        end else if (bus.exmem_memreq_i && !bus.dmem_ack_i) begin
            ho = 1; mb = 1; n_waiting = 1;
        end else if (bus.halt_i) begin
            ib = 1; n_halted = 1;
        end else if (lu) begin
            ib = 1;
        end else begin
            pc = 1; fw = 1; fl = bus.id_br_taken_i;
        end
        active = m_started && !m_halted;
        e.ctrl   = {pc, fw, fl, ib, ho, mb};
        e.halted = m_halted;
        e.cyc = m_cyc; e.stall = m_stall; e.flush = m_flush;
        exp_q.push_back(e);
        n_cyc   = m_cyc + (active ? 1 : 0);
        n_stall = m_stall + ((active && !pc) ? 1 : 0);
        n_flush = m_flush + (fl ? 1 : 0);
        if (!rst_n) begin
            n_started = 0; n_waiting = 0; n_halted = 0;
            n_cyc = 0; n_stall = 0; n_flush = 0;
        end
        @(posedge clk);
        m_started = n_started; m_waiting = n_waiting; m_halted = n_halted;
        m_cyc = n_cyc; m_stall = n_stall; m_flush = n_flush;
        #1;
    endtask

    task automatic quiet();
        rst_n = 1; bus.start_i = 1; bus.halt_i = 0;
        bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.id_rs1_use_i = 0; bus.id_rs2_use_i = 0;
        bus.id_br_taken_i = 0; bus.idex_memread_i = 0; bus.idex_rd_i = 0;
        bus.exmem_memreq_i = 0; bus.dmem_ack_i = 0;
    endtask

    task automatic randomize_inputs();
        rst_n              = ($urandom_range(0, 39) != 0);
        bus.start_i        = ($urandom_range(0, 3) != 0);
        bus.halt_i         = ($urandom_range(0, 49) == 0);
        bus.id_rs1_i       = 5'($urandom_range(0, 3));
        bus.id_rs2_i       = 5'($urandom_range(0, 3));
        bus.id_rs1_use_i   = 1'($urandom_range(0, 1));
        bus.id_rs2_use_i   = 1'($urandom_range(0, 1));
        bus.id_br_taken_i  = ($urandom_range(0, 3) == 0);
        bus.idex_memread_i = 1'($urandom_range(0, 1));
        bus.idex_rd_i      = 5'($urandom_range(0, 3));
        bus.exmem_memreq_i = ($urandom_range(0, 3) == 0);
        bus.dmem_ack_i     = 1'($urandom_range(0, 1));
    endtask

    initial begin
        m_started = 0; m_waiting = 0; m_halted = 0;
        m_cyc = 0; m_stall = 0; m_flush = 0;
        quiet();
        // T1: reset low two cycles (first cycle unchecked, state unknown), then run.
        rst_n = 0;
        @(posedge clk); #1;
        step();
        rst_n = 1;
        step();                     // IDLE with start -> RUN
        step(); step();             // RUN, free flow
        // T2: load-use on rs2, then same with rd=0.
        bus.idex_memread_i = 1; bus.idex_rd_i = 5; bus.id_rs2_i = 5; bus.id_rs2_use_i = 1;
        step();
        bus.idex_memread_i = 0;
        step();
        bus.idex_memread_i = 1; bus.idex_rd_i = 0; bus.id_rs2_i = 0;
        step();
        quiet();
        // T3: load-use together with taken branch.
        bus.idex_memread_i = 1; bus.idex_rd_i = 7; bus.id_rs1_i = 7; bus.id_rs1_use_i = 1;
        bus.id_br_taken_i = 1;
        step();
        bus.idex_memread_i = 0;
        step();
        quiet();
        // Same-cycle ack does not stall.
        bus.exmem_memreq_i = 1; bus.dmem_ack_i = 1;
        step();
        // T4: request acked after three stall cycles.
        bus.dmem_ack_i = 0;
        step(); step(); step();
        bus.dmem_ack_i = 1;
        step();
        quiet();
        step();
        // T5: reset in the middle of MEM_WAIT.
        bus.exmem_memreq_i = 1;
        step(); step();
        rst_n = 0;
        step();
        quiet(); bus.start_i = 0;
        step(); step();
        bus.start_i = 1;
        step(); step();
        // T6: halt, then start/branch ignored while halted.
        bus.halt_i = 1;
        step();
        bus.halt_i = 0; bus.id_br_taken_i = 1;
        step(); step(); step();
        quiet();
        rst_n = 0;
        step();
        quiet();
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end
        quiet();
        @(negedge clk); @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
